frame_dma_writer: RTL and testbench
===================================

Name: frame_dma_writer

Overview:
- Avalon-MM burst write master that moves one camera frame of 32-bit pixel words into the HPS DDR frame buffer.
- Sits directly downstream of the camera controller's pixel stream output, inside the Qsys system, on the system clock domain.
- Per frame: software-visible config is sampled on `start`; the input stream is buffered in a local FIFO; fixed-length bursts are issued; `done` is pulsed when the last word is accepted by the interconnect.

Parameters:
- DATA_W, 32, stream and Avalon data width in bits. Byte lanes = DATA_W/8.
- ADDR_W, 32, Avalon byte address width.
- BURST_LEN, 16, beats per full burst. Power of 2, ≤ FIFO_DEPTH.
- FIFO_DEPTH, 32, input FIFO entries. Power of 2.
- CNT_W, 24, width of the frame word counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begin a frame transfer
- frame_base  in  ADDR_W  byte address of frame buffer. Must be aligned to DATA_W/8.
- frame_words  in  CNT_W  number of DATA_W words in the frame
- in_data  in  DATA_W  pixel word from camera controller
- in_valid  in  1  in_data valid
- in_sof  in  1  start-of-frame marker, qualified by in_valid
- in_ready  out  1  block accepts in_data this cycle
- avm_address  out  ADDR_W  burst start byte address
- avm_write  out  1  write request
- avm_writedata  out  DATA_W  write beat data
- avm_burstcount  out  log2(BURST_LEN)+1  beats in current burst
- avm_waitrequest  in  1  interconnect stall
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset:
  - Synchronous, active-low, takes effect at the next clk edge.
  - All outputs are 0 out of reset: in_ready, avm_write, busy, done, avm_address, avm_burstcount, avm_writedata.
  - FIFO is emptied; FSM goes to IDLE.
  - A reset during a burst drops avm_write at that edge; the partial burst is abandoned.
- Handshakes:
  - Stream: a word is transferred when in_valid && in_ready.
  - Avalon: a beat completes when avm_write && !avm_waitrequest.
  - While waitrequest is high, avm_address, avm_burstcount and avm_writedata are held stable.
- Counters:
  - acc_cnt counts words accepted from the stream.
  - wr_cnt counts beats completed on Avalon.
  - Both are loaded to 0 on start.
- in_ready = busy && !fifo_full && (acc_cnt < frame_words_q). Excess stream words are back-pressured, not dropped.
- FSM:
  - IDLE:
    - On start, latch frame_base to addr_q and frame_words to frame_words_q; set busy=1.
    - If frame_words == 0, go to DONE; otherwise go to WAIT_DATA.
    - `start` is ignored in every state except IDLE.
  - WAIT_DATA:
    - rem = frame_words_q − wr_cnt; blen = min(BURST_LEN, rem).
    - When fifo_count ≥ blen, go to BURST.
    - avm_burstcount = blen, avm_address = addr_q, avm_write = 1, first beat presented.
  - BURST:
    - Each completed beat pops the FIFO and presents the next word. The FIFO is first-word-fall-through, so there are no bubbles while data is present.
    - The FIFO always holds the full burst before the burst starts, so avm_write never deasserts mid-burst.
    - After beat blen: addr_q += blen×(DATA_W/8).
    - If wr_cnt == frame_words_q, go to DONE; otherwise go to WAIT_DATA.
  - DONE:
    - done = 1 for exactly one cycle; busy = 0; next state IDLE.
- Latency:
  - First avm_write is asserted 1 cycle after the BURST_LEN-th word is accepted, or after the last word for a short frame.
  - done is asserted 1 cycle after the final beat completes.
- Boundaries:
  - frame_words not a multiple of BURST_LEN: the final burst is short, burstcount = remainder.
  - FIFO full: in_ready = 0.
  - Simultaneous FIFO push and pop: allowed; count is unchanged.
  - Address counter wraps modulo 2^ADDR_W with no error flag.

Optional Feature:
- Macro: FRAME_DMA_SOF_SYNC_EN.
- Defined:
  - After start, the FSM waits in an extra SYNC state with in_ready = 1, discarding words until a word with in_valid && in_sof arrives.
  - That word is the first accepted word (acc_cnt = 1) and the FSM moves to WAIT_DATA.
  - in_sof seen on later words mid-frame is ignored.
- Undefined:
  - in_sof is unused; words are accepted immediately after start.

Decomposition:
- Package frame_dma_pkg:
  - state enum {IDLE, SYNC, WAIT_DATA, BURST, DONE};
  - BYTES_PER_WORD constant;
  - burstcount width function clog2(BURST_LEN)+1.
- Sub-module frame_dma_fifo:
  - synchronous first-word-fall-through FIFO;
  - params DATA_W, FIFO_DEPTH;
  - ports push, pop, full, empty, count.
- The top level holds the FSM, counters and Avalon logic.

Test Plan:
- Basic frame:
  - Stimulus: frame_base=0x2000_0000, frame_words=32, continuous in_valid, waitrequest=0.
  - Required: two bursts of 16 at 0x2000_0000 and 0x2000_0040, data in order, done pulse once, busy low after.
- Short tail:
  - Stimulus: frame_words=20.
  - Required: bursts with burstcount 16 then 4, second address base+0x40, done after the 20th beat.
- Waitrequest stalls:
  - Stimulus: random waitrequest at 50% with frame_words=48.
  - Required: address, burstcount and writedata held stable during every stall; 48 beats exact; no avm_write gap inside a burst.
- Back-pressure and zero-length:
  - Stimulus: stream 40 words with frame_words=32, then a second start with frame_words=0.
  - Required: in_ready drops after word 32; the zero-length start gives done 1 cycle later with no avm_write.
- Reset mid-burst:
  - Stimulus: assert reset_n=0 on beat 5 of a burst.
  - Required: at the next edge avm_write=0, busy=0, FIFO empty; a new start then transfers correctly from frame_base.
- SOF sync (FRAME_DMA_SOF_SYNC_EN defined):
  - Stimulus: 3 junk words, then sof on word 0xA5A5_0000.
  - Required: the first written beat equals 0xA5A5_0000; the junk words are never written.

Source files
------------

// File: rtl/frame_dma_pkg.sv
// Shared types and helpers for the frame DMA writer.
package frame_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_WAIT_DATA,
    ST_BURST,
    ST_DONE
  } state_t;

  localparam int DEF_DATA_W     = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_W / 8;

  // Width of avm_burstcount: must be able to hold the value BURST_LEN itself.
  function automatic int bc_width(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/frame_dma_writer_if.sv
// Pixel stream input plus Avalon-MM burst write bus of the frame DMA writer.
//
// Handshakes: a stream word moves on a clock edge where in_valid && in_ready;
// an Avalon beat completes on a clock edge where avm_write && !avm_waitrequest,
// and while avm_waitrequest is high the master holds avm_address,
// avm_burstcount and avm_writedata stable.
interface frame_dma_writer_if #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int BURST_LEN = 16
);
  import frame_dma_pkg::*;

  localparam int BC_W = bc_width(BURST_LEN);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_sof;
  logic              in_ready;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [BC_W-1:0]   avm_burstcount;
  logic              avm_waitrequest;

  // DMA side: consumes the stream, drives the Avalon master
  modport master (
    input  in_data, in_valid, in_sof, avm_waitrequest,
    output in_ready, avm_address, avm_write, avm_writedata, avm_burstcount
  );

  // Environment side: camera stream source and Avalon interconnect
  modport slave (
    output in_data, in_valid, in_sof, avm_waitrequest,
    input  in_ready, avm_address, avm_write, avm_writedata, avm_burstcount
  );

endinterface

// File: rtl/frame_dma_fifo.sv
// Synchronous first-word-fall-through FIFO: dout always shows the head entry.
module frame_dma_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push,
  input  logic [DATA_W-1:0]             din,
  input  logic                          pop,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking; simultaneous push and pop keep count
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/frame_dma_writer.sv
// Frame DMA writer: buffers one frame of pixel words and writes it to memory
// as fixed-length Avalon-MM bursts (short final burst for a remainder).
// Optional build macro FRAME_DMA_SOF_SYNC_EN: after start, discard stream
// words until one arrives with in_sof set; that word is the frame's first.
module frame_dma_writer
  import frame_dma_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int BURST_LEN  = 16,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 24
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    frame_base,
  input  logic [CNT_W-1:0]     frame_words,
  output logic                 busy,
  output logic                 done,
  output state_t               fsm_state,
  frame_dma_writer_if.master   bus
);
  localparam int BC_W = bc_width(BURST_LEN);
  localparam int FC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BPW  = DATA_W / 8;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  frame_words_q;
  logic [CNT_W-1:0]  acc_cnt;
  logic [CNT_W-1:0]  wr_cnt;
  logic [BC_W-1:0]   beat_cnt;

  logic              avm_write_q;
  logic [ADDR_W-1:0] avm_address_q;
  logic [BC_W-1:0]   avm_burstcount_q;
  logic [DATA_W-1:0] avm_writedata_q;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic [FC_W-1:0]   fifo_count;

  logic [CNT_W-1:0]  rem;
  logic [BC_W-1:0]   blen_next;
  logic              burst_go;
  logic              beat_done;
  logic              beat_last;
  logic              in_ready_int;

  frame_dma_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .din     (bus.in_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next burst length: a full burst, or whatever is left of the frame
  assign rem       = frame_words_q - wr_cnt;
  assign blen_next = (rem >= CNT_W'(BURST_LEN)) ? BC_W'(BURST_LEN) : rem[BC_W-1:0];

  // A burst only starts once all of its words sit in the FIFO
  assign burst_go  = (state == ST_WAIT_DATA) && !fifo_empty &&
                     (32'(fifo_count) >= 32'(blen_next));
  assign beat_done = avm_write_q && !bus.avm_waitrequest;
  assign beat_last = beat_done && (beat_cnt == avm_burstcount_q - BC_W'(1));

  // The writedata register is the presentation stage: a word leaves the FIFO
  // when it is loaded there, i.e. at burst start and after each non-final beat
  assign fifo_pop  = burst_go || (beat_done && !beat_last);

  // Words beyond the frame length are back-pressured, never dropped
  assign in_ready_int = busy && !fifo_full && (acc_cnt < frame_words_q);

`ifdef FRAME_DMA_SOF_SYNC_EN
  // While synchronising, every offered word is consumed but only SOF is kept
  assign fifo_push = bus.in_valid && in_ready_int &&
                     ((state != ST_SYNC) || bus.in_sof);
`else
  logic sof_unused;
  assign sof_unused = bus.in_sof;
  assign fifo_push  = bus.in_valid && in_ready_int;
`endif

  assign bus.in_ready       = in_ready_int;
  assign bus.avm_write      = avm_write_q;
  assign bus.avm_address    = avm_address_q;
  assign bus.avm_burstcount = avm_burstcount_q;
  assign bus.avm_writedata  = avm_writedata_q;
  assign fsm_state          = state;

  // Frame sequencing, counters and registered Avalon outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      addr_q           <= '0;
      frame_words_q    <= '0;
      acc_cnt          <= '0;
      wr_cnt           <= '0;
      beat_cnt         <= '0;
      avm_write_q      <= 1'b0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      avm_writedata_q  <= '0;
    end else begin
      done <= 1'b0;
      if (fifo_push) acc_cnt <= acc_cnt + CNT_W'(1);

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q        <= frame_base;
            frame_words_q <= frame_words;
            acc_cnt       <= '0;
            wr_cnt        <= '0;
            if (frame_words == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else begin
              busy <= 1'b1;
`ifdef FRAME_DMA_SOF_SYNC_EN
              state <= ST_SYNC;
`else
              state <= ST_WAIT_DATA;
`endif
            end
          end
        end

        ST_SYNC: begin
          if (fifo_push) state <= ST_WAIT_DATA;
        end

        ST_WAIT_DATA: begin
          if (burst_go) begin
            state            <= ST_BURST;
            avm_write_q      <= 1'b1;
            avm_address_q    <= addr_q;
            avm_burstcount_q <= blen_next;
            avm_writedata_q  <= fifo_dout;
            beat_cnt         <= '0;
          end
        end

        ST_BURST: begin
          if (beat_done) begin
            wr_cnt <= wr_cnt + CNT_W'(1);
            if (beat_last) begin
              avm_write_q <= 1'b0;
              addr_q      <= addr_q + ADDR_W'(avm_burstcount_q) * ADDR_W'(BPW);
              if (wr_cnt + CNT_W'(1) == frame_words_q) begin
                state <= ST_DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= ST_WAIT_DATA;
              end
            end else begin
              beat_cnt        <= beat_cnt + BC_W'(1);
              avm_writedata_q <= fifo_dout;
            end
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_dma_writer.sv
// Randomised bench for frame_dma_writer: a frame-level model predicts burst
// addresses, lengths, beat data and handshake timing.
module tb_frame_dma_writer;
  import frame_dma_pkg::*;

  localparam int BURST_LEN = 16;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] frame_base;
  logic [23:0] frame_words;
  logic        busy;
  logic        done;
  state_t      fsm_state;

  always #5 clk = ~clk;

  frame_dma_writer_if bus ();

  frame_dma_writer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .frame_base  (frame_base),
    .frame_words (frame_words),
    .busy        (busy),
    .done        (done),
    .fsm_state   (fsm_state),
    .bus         (bus)
  );

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // ---------------- frame driver + monitor ----------------
  task automatic run_frame(input logic [31:0] base, input int n, input int nsrc,
                           input int junk, input int valid_pct, input int wait_pct,
                           input int rst_beat);
    logic [31:0] src_q[$];
    logic        sof_q[$];
    logic [31:0] exp_addr_q[$];
    int          exp_len_q[$];
    int          idx, accepted, beats, beats_left, dones, bursts;
    int          cyc, acc_cyc, last_beat_cyc, first_blen;
    logic        prev_stall;
    logic [31:0] prev_addr, prev_data;
    logic [4:0]  prev_bc;
    bit          finished;

    idx = 0; accepted = 0; beats = 0; beats_left = 0; dones = 0; bursts = 0;
    cyc = 0; acc_cyc = -100; last_beat_cyc = -1; finished = 0;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0; prev_bc = '0;
    exp_q.delete();

    for (int i = 0; i < junk + nsrc; i++) begin
      src_q.push_back($urandom);
`ifdef FRAME_DMA_SOF_SYNC_EN
      sof_q.push_back(i == junk ? 1'b1 : (i < junk ? 1'b0 : 1'($urandom_range(1))));
`else
      sof_q.push_back(1'($urandom_range(1)));
`endif
    end
    if (junk > 0) src_q[junk] = 32'hA5A5_0000;

    // Reference: the frame is the n words starting at the first kept word,
    // cut into BURST_LEN chunks at consecutive word addresses
    for (int i = 0; i < n; i++) exp_q.push_back(src_q[junk + i]);
    for (int off = 0; off < n; off += BURST_LEN) begin
      exp_addr_q.push_back(base + 32'(off * BYTES_PER_WORD));
      exp_len_q.push_back((n - off < BURST_LEN) ? n - off : BURST_LEN);
    end
    first_blen = (n < BURST_LEN) ? n : BURST_LEN;

    @(negedge clk);
    start = 1'b1; frame_base = base; frame_words = 24'(n);
    @(negedge clk);
    start = 1'b0;

    while (!finished && cyc < 3000) begin
      if (done) begin
        dones++;
        check("done_latency", cyc, last_beat_cyc + 1);
        check("busy_at_done", busy, 0);
        finished = 1;
      end

      if (prev_stall) begin
        check("stall_write", bus.avm_write, 1);
        check("stall_addr", bus.avm_address, prev_addr);
        check("stall_count", bus.avm_burstcount, prev_bc);
        check("stall_data", bus.avm_writedata, prev_data);
      end else if (beats_left > 0) begin
        check("burst_gap", bus.avm_write, 1);
      end

      if (bus.avm_write && beats_left == 0) begin
        if (exp_addr_q.size() == 0) check("burst_extra", bus.avm_write, 0);
        else begin
          check("burst_addr", bus.avm_address, exp_addr_q.pop_front());
          check("burst_count", bus.avm_burstcount, exp_len_q.pop_front());
          if (bursts == 0) check("first_write_latency", cyc, acc_cyc + 2);
          bursts++;
          beats_left = int'(bus.avm_burstcount);
        end
      end

      if (rst_beat >= 0 && bus.avm_write && beats == rst_beat) begin
        reset_n = 1'b0; bus.avm_waitrequest = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("rst_avm_write", bus.avm_write, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_state", fsm_state, ST_IDLE);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        exp_q.delete();
        return;
      end

      bus.avm_waitrequest = ($urandom_range(99) < wait_pct);
      if (bus.avm_write && !bus.avm_waitrequest) begin
        if (exp_q.size() == 0) check("beat_extra", bus.avm_write, 0);
        else check("beat_data", bus.avm_writedata, exp_q.pop_front());
        beats++;
        beats_left--;
        last_beat_cyc = cyc;
      end
      prev_stall = bus.avm_write && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      prev_bc    = bus.avm_burstcount;
      prev_data  = bus.avm_writedata;

      if (idx < src_q.size() && $urandom_range(99) < valid_pct) begin
        bus.in_valid = 1'b1; bus.in_data = src_q[idx]; bus.in_sof = sof_q[idx];
      end else begin
        bus.in_valid = 1'b0; bus.in_data = $urandom; bus.in_sof = 1'($urandom_range(1));
      end
      if (bus.in_valid && (idx - junk) >= n) check("backpressure", bus.in_ready, 0);
      if (bus.in_valid && bus.in_ready) begin
        if (idx >= junk) begin
          accepted++;
          if (accepted == first_blen) acc_cyc = cyc;
        end
        idx++;
      end

      cyc++;
      @(negedge clk);
    end

    check("done_count", dones, 1);
    check("beat_total", beats, n);
    check("accepted_words", accepted, n);
    check("data_left", exp_q.size(), 0);
    check("bursts_left", exp_addr_q.size(), 0);
    bus.in_valid = 1'b0; bus.avm_waitrequest = 1'b0;
    repeat (3) begin
      check("done_single", done, 0);
      check("busy_after", busy, 0);
      @(negedge clk);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int rn;
    reset_n = 1'b0; start = 1'b0; frame_base = '0; frame_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_sof = 1'b0; bus.avm_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_avm_write", bus.avm_write, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_address", bus.avm_address, 0);
    check("reset_burstcount", bus.avm_burstcount, 0);
    check("reset_writedata", bus.avm_writedata, 0);
    check("reset_state", fsm_state, ST_IDLE);
    reset_n = 1'b1;
    @(negedge clk);

    run_frame(32'h2000_0000, 32, 32, 0, 100, 0, -1);   // basic frame
    run_frame(32'h2000_0000, 20, 20, 0, 100, 0, -1);   // short tail
    run_frame(32'h3000_0100, 48, 48, 0, 70, 50, -1);   // waitrequest stalls
    run_frame(32'h2000_0000, 32, 40, 0, 100, 0, -1);   // excess words
    run_frame(32'h2000_0000, 0, 0, 0, 100, 0, -1);     // zero length
    run_frame(32'h2000_0000, 32, 32, 0, 100, 0, 4);    // reset on beat 5
    run_frame(32'h2000_0000, 32, 32, 0, 100, 0, -1);   // recovery
    run_frame(32'hFFFF_FFC0, 40, 40, 0, 60, 30, -1);   // address wrap
    for (int k = 0; k < 6; k++) begin
      rn = $urandom_range(1, 60);
      run_frame($urandom & 32'hFFFF_FFFC, rn, rn + $urandom_range(0, 5), 0,
                $urandom_range(30, 100), $urandom_range(0, 60), -1);
    end
`ifdef FRAME_DMA_SOF_SYNC_EN
    run_frame(32'h2000_0000, 20, 20, 3, 100, 0, -1);   // junk then SOF word
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
